// File: rtl/bootrom_pkg.sv
// Shared types and constants for the boot ROM arbiter slice.
package bootrom_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Master index: 0 = CPU fetch/data, 1 = BIOS shadow-copy engine
    typedef logic mst_idx_t;

    localparam int unsigned ROM_AW_DEF      = 13;
    localparam int unsigned ROM_LATENCY_MAX = 3;
    localparam int unsigned CNT_W           = $clog2(ROM_LATENCY_MAX);

    // Initial WAIT down-counter value for a given ROM read latency
    function automatic logic [CNT_W-1:0] wait_cycles(input int unsigned lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/bootrom_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-grant register.
// On a tie the master that was not granted last wins; last_grant resets to 1
// so master 0 wins the first tie after reset.
module rr_arb2
    import bootrom_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    mst_idx_t last_grant_q;
    mst_idx_t last_grant_d;

    // Grant decision and last-grant update
    always_comb begin
        gnt          = '0;
        last_grant_d = last_grant_q;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_grant_q == 1'b1) ? 2'b01 : 2'b10;
                default: gnt = '0;
            endcase
            if (gnt != '0) begin
                last_grant_d = gnt[1];
            end
        end
    end

    // Last-grant register
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/bootrom_arbiter.sv
// Two-master Wishbone classic arbiter/sequencer in front of a registered-output
// boot ROM. Optional macro BOOTROM_ARB_WERR_EN adds m0_err_o/m1_err_o and
// answers writes with err instead of ack.
module bootrom_arbiter
    import bootrom_pkg::*;
#(
    parameter int unsigned ROM_AW      = ROM_AW_DEF,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [19:1]       m0_adr_i,
    input  logic              m0_we_i,
    input  logic              m0_stb_i,
    input  logic              m0_cyc_i,
    input  logic [1:0]        m0_sel_i,
    output logic [15:0]       m0_dat_o,
    output logic              m0_ack_o,
`ifdef BOOTROM_ARB_WERR_EN
    output logic              m0_err_o,
`endif
    input  logic [19:1]       m1_adr_i,
    input  logic              m1_we_i,
    input  logic              m1_stb_i,
    input  logic              m1_cyc_i,
    input  logic [1:0]        m1_sel_i,
    output logic [15:0]       m1_dat_o,
    output logic              m1_ack_o,
`ifdef BOOTROM_ARB_WERR_EN
    output logic              m1_err_o,
`endif
    output logic [ROM_AW-1:0] rom_addr_o,
    output logic              rom_en_o,
    input  logic [15:0]       rom_q_i
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    mst_idx_t           sel_q, sel_d;
    logic               wr_q, wr_d;
    logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
    logic               rom_en_q, rom_en_d;
    logic [1:0]         ack_q, ack_d;
    logic [15:0]        dat0_q, dat0_d;
    logic [15:0]        dat1_q, dat1_d;
`ifdef BOOTROM_ARB_WERR_EN
    logic [1:0]         err_q, err_d;
`endif

    logic [1:0] req;
    logic [1:0] gnt;
    logic       arb_en;

    // Byte selects and address bits above the ROM window are don't-care for reads
    logic unused_inputs;
    assign unused_inputs = ^{m0_sel_i, m1_sel_i, m0_adr_i[19:ROM_AW+1], m1_adr_i[19:ROM_AW+1]};

    assign req    = {m1_stb_i & m1_cyc_i, m0_stb_i & m0_cyc_i};
    assign arb_en = (state_q == IDLE);

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req (req),
        .gnt (gnt)
    );

    // Sequencer next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        wr_d       = wr_q;
        rom_addr_d = rom_addr_q;
        rom_en_d   = 1'b0;
        ack_d      = '0;
        dat0_d     = dat0_q;
        dat1_d     = dat1_q;
`ifdef BOOTROM_ARB_WERR_EN
        err_d      = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (gnt != '0) begin
                    sel_d = gnt[1];
                    wr_d  = gnt[1] ? m1_we_i : m0_we_i;
                    cnt_d = wait_cycles(ROM_LATENCY);
                    if (wr_d) begin
                        state_d = ACK;
`ifdef BOOTROM_ARB_WERR_EN
                        err_d[sel_d] = 1'b1;
`else
                        ack_d[sel_d] = 1'b1;
`endif
                    end else begin
                        state_d    = WAIT;
                        rom_en_d   = 1'b1;
                        rom_addr_d = gnt[1] ? m1_adr_i[ROM_AW:1] : m0_adr_i[ROM_AW:1];
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    ack_d[sel_q] = 1'b1;
                    state_d      = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
                if (!wr_q) begin
                    if (sel_q) begin
                        dat1_d = rom_q_i;
                    end else begin
                        dat0_d = rom_q_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= 1'b0;
            wr_q       <= 1'b0;
            rom_addr_q <= '0;
            rom_en_q   <= 1'b0;
            ack_q      <= '0;
            dat0_q     <= '0;
            dat1_q     <= '0;
`ifdef BOOTROM_ARB_WERR_EN
            err_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            wr_q       <= wr_d;
            rom_addr_q <= rom_addr_d;
            rom_en_q   <= rom_en_d;
            ack_q      <= ack_d;
            dat0_q     <= dat0_d;
            dat1_q     <= dat1_d;
`ifdef BOOTROM_ARB_WERR_EN
            err_q      <= err_d;
`endif
        end
    end

    // The ROM output register only becomes valid in the ack cycle, so read
    // data is passed through while ack is high and held from the end of it.
    assign m0_dat_o   = (ack_q[0] && !wr_q) ? rom_q_i : dat0_q;
    assign m1_dat_o   = (ack_q[1] && !wr_q) ? rom_q_i : dat1_q;
    assign m0_ack_o   = ack_q[0];
    assign m1_ack_o   = ack_q[1];
    assign rom_addr_o = rom_addr_q;
    assign rom_en_o   = rom_en_q;
`ifdef BOOTROM_ARB_WERR_EN
    assign m0_err_o   = err_q[0];
    assign m1_err_o   = err_q[1];
`endif

endmodule
